alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor to the 8-bit combinational ALU. Same 3-bit f opcode map; the
//  unused code 011 becomes an iterative multiply. Adds valid/ready handshakes on both sides, a
//  registered result with NZCV flags, and a signed SLT corrected for overflow. Sits between the
//  operand fetch and writeback stages of the datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  reset      in   1      asynchronous, active-high; clears all state immediately
//  in_valid   in   1      a, b and f are valid
//  in_ready   out  1      block accepts an operation at this edge
//  a, b       in   WIDTH  operands
//  f          in   3      000 AND, 001 OR, 010 ADD, 011 MUL, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT
//  out_valid  out  1      y and flags hold a result
//  out_ready  in   1      consumer takes the result at this edge
//  y          out  WIDTH  result
//  zero, negative, carry, overflow  out  1 each  flags of y (see below)
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, y=0, all flags=0, MUL counter=0. in_ready=0 while reset=1.
//  - Accept: in_valid && in_ready at an edge. Output: out_valid && out_ready at an edge.
//  - in_ready = !reset && state==IDLE && (!out_valid || out_ready). Combinational; it is the only
//    comb path from out_ready to an output.
//  - Non-MUL ops: result and flags are registered at the accept edge. out_valid=1 after that edge
//    (latency 1). Accept and drain at the same edge overwrite the register. Throughput is 1/cycle.
//  - MUL FSM IDLE->BUSY on accept with f=011. Load acc=0, mcand=a, mplier=b, cnt=0.
//    * Each BUSY edge does one shift-add step and cnt++.
//    * At the WIDTH-th step (accept edge + WIDTH), write y = product[WIDTH-1:0], set out_valid=1,
//      and return to IDLE.
//    * in_ready=0 throughout BUSY. The output register is always empty during BUSY, because
//      acceptance requires it empty or draining, so no wait state is needed.
//  - Backpressure: while out_valid && !out_ready, y and all flags are held stable.
//  - Arithmetic: all ops are modulo 2^WIDTH.
//    * ADD: {c,y} = a+b.
//    * SUB: {c,y} = a + ~b + 1. carry=1 means no borrow.
//    * overflow (ADD/SUB) = signed overflow of the add/sub result.
//    * SLT: y = ($signed(a) < $signed(b)) zero-extended, taken as neg XOR ovf of the SUB.
//      SLT flags: carry=0, overflow=0.
//    * MUL is unsigned: carry=1 iff product[2*WIDTH-1:WIDTH] != 0, overflow=0.
//    * Logic ops: carry=0, overflow=0.
//  - zero = (y==0); negative = y[WIDTH-1], for every op.
//  - Reset mid-MUL aborts the multiply. No output is produced for it; the block returns to IDLE.
//  - in_valid with f=011 while in BUSY is simply not accepted; the upstream holds it.
// STRUCTURE
//  - alu_pkg holds typedef enum logic [2:0] alu_op_t (OP_AND..OP_SLT in the encoding above) and
//    typedef enum logic {IDLE, BUSY} alu_state_t.
//  - Sub-module alu_mul_iter(WIDTH) is the shift-add datapath plus counter, with ports start,
//    busy, done and a 2*WIDTH product. alu_seq holds the FSM, the comb op unit, and the output
//    register.
// TESTING (WIDTH=8)
//  - a=AA b=55, f=000/001/100/101, out_ready=1:
//    y=00 Z=1; y=FF N=1; y=AA; y=AA. Each result 1 cycle after accept.
//  - a=6C b=7E:
//    ADD -> y=EA N=1 C=0 V=1; SUB -> y=EE N=1 C=0 V=0; SLT -> y=01 Z=0.
//  - SLT overflow case a=80 b=01 -> y=01 (SUB result 7F, V=1; neg^ovf=1).
//  - MUL a=6C b=7E -> in_ready=0 for 8 cycles, then y=28, C=1 (0x3528), at accept edge+8.
//    MUL a=0F b=11 -> y=FF C=0.
//  - Backpressure: hold out_ready=0 for 5 cycles after an ADD result.
//    y and flags stay stable, in_ready=0. Then 1 cycle of out_ready=1 with a new op pending ->
//    drain and accept at the same edge.
//  - Assert reset 3 cycles into a MUL -> out_valid=0 and y=0 immediately (async).
//    After release, no stale MUL result appears and the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and FSM states shared by the sequential ALU
package alu_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_MUL  = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLT  = 3'b111
  } alu_op_t;
  typedef enum logic {IDLE, BUSY} alu_state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: one-bit-per-cycle shift-add unsigned multiplier
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               busy,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  // product is the accumulator after the current step, so it is final when done is high
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, NZCV flags and iterative multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);
  alu_state_t state, state_d;
  alu_op_t op;
  logic accept, mul_start, mul_done, sub, ovf, rc, rv;
  logic [WIDTH-1:0] bb, s, r;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] product;
  assign op        = alu_op_t'(f);
  assign in_ready  = !reset && state == IDLE && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && op == OP_MUL;
  assign sub       = op == OP_SUB || op == OP_SLT;
  assign bb        = sub ? ~b : b;
  assign sum       = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(sub);
  assign s         = sum[WIDTH-1:0];
  assign ovf       = a[WIDTH-1] == bb[WIDTH-1] && s[WIDTH-1] != a[WIDTH-1];
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .busy   (state == BUSY),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(product)
  );
  always_comb begin
    r  = '0;
    rc = 1'b0;
    rv = 1'b0;
    case (op)
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_ANDN:        r = a & ~b;
      OP_ORN:         r = a | ~b;
      OP_ADD, OP_SUB: begin
        r  = s;
        rc = sum[WIDTH];
        rv = ovf;
      end
      OP_SLT:         r = WIDTH'(s[WIDTH-1] ^ ovf);
      default:        r = '0;
    endcase
  end
  always_comb state_d = state == IDLE ? (mul_start ? BUSY : IDLE) : (mul_done ? IDLE : BUSY);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end
  // busy implies an empty output register, so a finishing multiply never collides with a held result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept && op != OP_MUL) begin
      out_valid <= 1'b1;
      y         <= r;
      zero      <= r == '0;
      negative  <= r[WIDTH-1];
      carry     <= rc;
      overflow  <= rv;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      y         <= product[WIDTH-1:0];
      zero      <= product[WIDTH-1:0] == '0;
      negative  <= product[WIDTH-1];
      carry     <= |product[2*WIDTH-1:WIDTH];
      overflow  <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero, negative, carry, overflow;
  logic [7:0] a = 0, b = 0, y;
  logic [2:0] f = 0;
  int checks = 0, failures = 0;
  logic [11:0] hold;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] model(input logic [7:0] ma, mb, input logic [2:0] mf);
    int sa, sb, rr;
    logic [7:0] ry, nb;
    logic c, v;
    sa = $signed(ma);
    sb = $signed(mb);
    nb = ~mb;
    c = 0;
    v = 0;
    ry = 0;
    case (mf)
      3'd0: ry = ma & mb;
      3'd1: ry = ma | mb;
      3'd4: ry = ma & nb;
      3'd5: ry = ma | nb;
      3'd2: begin
        rr = int'(ma) + int'(mb); ry = rr[7:0]; c = rr > 255;
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd6: begin
        rr = int'(ma) + int'(nb) + 1; ry = rr[7:0]; c = rr > 255;
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd7: ry = (sa < sb) ? 8'd1 : 8'd0;
      default: begin
        rr = int'(ma) * int'(mb); ry = rr[7:0]; c = rr > 255;
      end
    endcase
    return {ry, ry == 0, ry[7], c, v};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {y, zero, negative, carry, overflow};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] oa, ob, input logic [2:0] of_, input string tag);
    int n;
    a = oa; b = ob; f = of_; in_valid = 1;
    #1;
    chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    step();
    in_valid = 0;
    #0;
    if (of_ == 3'd3) begin
      n = 0;
      while (!out_valid && n < 20) begin
        chk({tag, "_busy_in_ready"}, 16'(in_ready), 16'd0);
        step();
        n++;
      end
      chk({tag, "_mul_latency"}, 16'(n), 16'd8);
    end
    chk({tag, "_valid"}, 16'(out_valid), 16'd1);
    chk({tag, "_result"}, 16'(obs()), 16'(model(oa, ob, of_)));
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_y_flags", 16'(obs()), 16'd0);
    step();
    step();
    reset = 0;
    step();
    chk("idle_in_ready", 16'(in_ready), 16'd1);

    do_op(8'hAA, 8'h55, 3'd0, "and");
    chk("and_const", 16'(obs()), 16'h008);
    do_op(8'hAA, 8'h55, 3'd1, "or");
    chk("or_const", 16'(obs()), 16'hFF4);
    do_op(8'hAA, 8'h55, 3'd4, "andn");
    do_op(8'hAA, 8'h55, 3'd5, "orn");
    do_op(8'h6C, 8'h7E, 3'd2, "add");
    chk("add_const", 16'(obs()), 16'hEA5);
    do_op(8'h6C, 8'h7E, 3'd6, "sub");
    chk("sub_const", 16'(obs()), 16'hEE4);
    do_op(8'h6C, 8'h7E, 3'd7, "slt");
    do_op(8'h80, 8'h01, 3'd7, "slt_ovf");
    chk("slt_ovf_const", 16'(obs()), 16'h010);
    do_op(8'h6C, 8'h7E, 3'd3, "mul");
    chk("mul_const", 16'(obs()), 16'h282);
    do_op(8'h0F, 8'h11, 3'd3, "mul2");
    chk("mul2_const", 16'(obs()), 16'hFF4);
    do_op(8'hFF, 8'hFF, 3'd3, "mul_max");
    do_op(8'h00, 8'h9C, 3'd3, "mul_zero");
    step();

    // backpressure: result held for five cycles, then drain and accept together
    out_ready = 0;
    do_op(8'h6C, 8'h7E, 3'd2, "bp_add");
    hold = model(8'h6C, 8'h7E, 3'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 16'(out_valid), 16'd1);
      chk("bp_stable", 16'(obs()), 16'(hold));
      chk("bp_in_ready", 16'(in_ready), 16'd0);
    end
    a = 8'h13; b = 8'h24; f = 3'd6; in_valid = 1; out_ready = 1;
    #1;
    chk("bp_drain_in_ready", 16'(in_ready), 16'd1);
    step();
    in_valid = 0;
    #0;
    chk("bp_next_valid", 16'(out_valid), 16'd1);
    chk("bp_next_result", 16'(obs()), 16'(model(8'h13, 8'h24, 3'd6)));
    step();
    chk("bp_drained", 16'(out_valid), 16'd0);

    // reset three cycles into a multiply
    a = 8'h6C; b = 8'h7E; f = 3'd3; in_valid = 1;
    step();
    in_valid = 0;
    step();
    step();
    step();
    reset = 1;
    #1;
    chk("abort_out_valid", 16'(out_valid), 16'd0);
    chk("abort_y_flags", 16'(obs()), 16'd0);
    chk("abort_in_ready", 16'(in_ready), 16'd0);
    step();
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_no_stale", 16'(out_valid), 16'd0);
    end
    do_op(8'h6C, 8'h7E, 3'd2, "post_abort_add");

    for (int i = 0; i < 150; i++)
      do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), "rand");

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
